// File: rtl/pipelined_dp_ram.sv
// Simple dual-port RAM with byte enables, 1- or 2-cycle read latency, selectable
// read-during-write and a post-reset clear sequencer. Optional parity: PIPELINED_DP_RAM_PARITY_EN.
module pipelined_dp_ram #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 11,
    parameter int RD_LAT  = 1,
    parameter int RDW_NEW = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_W-1:0]    w_adrs,
    input  logic [DATA_W-1:0]    w_data,
    input  logic [DATA_W/8-1:0]  w_be,
    input  logic                 w_en,
    input  logic                 w_perr_inj,
    input  logic [ADDR_W-1:0]    r_adrs,
    input  logic                 r_en,
    output logic [DATA_W-1:0]    rd_data,
    output logic                 rd_valid,
    output logic [DATA_W/8-1:0]  rd_perr,
    output logic                 busy
);

    // state | meaning
    // CLEAR | walking the address space writing zero; requests ignored
    // READY | normal read/write operation

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   clr_adrs;
    logic                clr_last;
    logic                clr_wr;
    logic                wr_acc;
    logic                rd_issue;
    logic                fwd;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   old_word;
    logic [DATA_W-1:0]   rd_word;
    logic [NB-1:0]       rd_perr_s0;

    assign clr_last = (clr_adrs == {ADDR_W{1'b1}});

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= CLEAR;
            clr_adrs <= '0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR) begin
                clr_adrs <= clr_adrs + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == CLEAR && clr_last) begin
            state_nxt = READY;
        end
    end

    always_comb begin
        busy     = (state == CLEAR);
        clr_wr   = (state == CLEAR) && !reset;
        wr_acc   = (state == READY) && !reset && w_en;
        rd_issue = (state == READY) && !reset && r_en;
    end

    always_ff @(posedge clk) begin
        if (clr_wr) begin
            mem[clr_adrs] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < NB; i++) begin
                if (w_be[i]) begin
                    mem[w_adrs][8*i +: 8] <= w_data[8*i +: 8];
                end
            end
        end
    end

    // Forwarding is decided here, before any output register stage.
    assign fwd      = (RDW_NEW != 0) && wr_acc && (w_adrs == r_adrs);
    assign old_word = mem[r_adrs];

    always_comb begin
        rd_word = old_word;
        for (int i = 0; i < NB; i++) begin
            if (fwd && w_be[i]) begin
                rd_word[8*i +: 8] = w_data[8*i +: 8];
            end
        end
    end

`ifdef PIPELINED_DP_RAM_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH];
    logic [NB-1:0] w_par;
    logic [NB-1:0] old_par;

    always_comb begin
        w_par = '0;
        for (int i = 0; i < NB; i++) begin
            w_par[i] = (^w_data[8*i +: 8]) ^ w_perr_inj;
        end
    end

    // Even parity of an all-zero byte is 0, so clearing stores zero parity.
    always_ff @(posedge clk) begin
        if (clr_wr) begin
            par_mem[clr_adrs] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < NB; i++) begin
                if (w_be[i]) begin
                    par_mem[w_adrs][i] <= w_par[i];
                end
            end
        end
    end

    assign old_par = par_mem[r_adrs];

    always_comb begin
        rd_perr_s0 = '0;
        for (int i = 0; i < NB; i++) begin
            if (fwd && w_be[i]) begin
                rd_perr_s0[i] = (^rd_word[8*i +: 8]) ^ w_par[i];
            end else begin
                rd_perr_s0[i] = (^rd_word[8*i +: 8]) ^ old_par[i];
            end
        end
    end
`else
    logic unused_perr_inj;
    assign unused_perr_inj = w_perr_inj;
    assign rd_perr_s0      = '0;
`endif

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              s1_valid;
            logic [DATA_W-1:0] s1_data;
            logic [NB-1:0]     s1_perr;

            always_ff @(posedge clk) begin
                if (reset) begin
                    s1_valid <= 1'b0;
                    s1_data  <= '0;
                    s1_perr  <= '0;
                    rd_valid <= 1'b0;
                    rd_data  <= '0;
                    rd_perr  <= '0;
                end else begin
                    s1_valid <= rd_issue;
                    if (rd_issue) begin
                        s1_data <= rd_word;
                        s1_perr <= rd_perr_s0;
                    end
                    rd_valid <= s1_valid;
                    if (s1_valid) begin
                        rd_data <= s1_data;
                        rd_perr <= s1_perr;
                    end
                end
            end
        end else begin : g_lat1
            always_ff @(posedge clk) begin
                if (reset) begin
                    rd_valid <= 1'b0;
                    rd_data  <= '0;
                    rd_perr  <= '0;
                end else begin
                    rd_valid <= rd_issue;
                    if (rd_issue) begin
                        rd_data <= rd_word;
                        rd_perr <= rd_perr_s0;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_pipelined_dp_ram.sv
// Directed bench for pipelined_dp_ram: one instance with RD_LAT=1/RDW_NEW=0 and
// one with RD_LAT=2/RDW_NEW=1 share the same stimulus.
module tb_pipelined_dp_ram;

    localparam int DW = 32;
    localparam int AW = 11;
    localparam int NB = DW / 8;
`ifdef PIPELINED_DP_RAM_PARITY_EN
    localparam logic [NB-1:0] INJ_PERR = 4'b0100;
`else
    localparam logic [NB-1:0] INJ_PERR = 4'b0000;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] w_adrs = '0;
    logic [DW-1:0] w_data = '0;
    logic [NB-1:0] w_be = '0;
    logic          w_en = 1'b0;
    logic          w_perr_inj = 1'b0;
    logic [AW-1:0] r_adrs = '0;
    logic          r_en = 1'b0;

    logic [DW-1:0] rd_data1, rd_data2;
    logic          rd_valid1, rd_valid2;
    logic [NB-1:0] rd_perr1, rd_perr2;
    logic          busy1, busy2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipelined_dp_ram #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1), .RDW_NEW(0)) u_dut1 (
        .clk(clk), .reset(reset), .w_adrs(w_adrs), .w_data(w_data), .w_be(w_be),
        .w_en(w_en), .w_perr_inj(w_perr_inj), .r_adrs(r_adrs), .r_en(r_en),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .rd_perr(rd_perr1), .busy(busy1)
    );

    pipelined_dp_ram #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(2), .RDW_NEW(1)) u_dut2 (
        .clk(clk), .reset(reset), .w_adrs(w_adrs), .w_data(w_data), .w_be(w_be),
        .w_en(w_en), .w_perr_inj(w_perr_inj), .r_adrs(r_adrs), .r_en(r_en),
        .rd_data(rd_data2), .rd_valid(rd_valid2), .rd_perr(rd_perr2), .busy(busy2)
    );

    typedef struct {
        logic [AW-1:0] adrs;
        logic [DW-1:0] data;
        logic [NB-1:0] be;
        logic          inj;
        logic [DW-1:0] exp_word;
        logic [NB-1:0] exp_perr;
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [NB-1:0] be, input logic inj);
        w_en = 1'b1; w_adrs = a; w_data = d; w_be = be; w_perr_inj = inj;
        tick();
        w_en = 1'b0; w_perr_inj = 1'b0;
    endtask

    task automatic do_read(input string name, input logic [AW-1:0] a,
                           input logic [DW-1:0] exp, input logic [NB-1:0] perr);
        r_en = 1'b1; r_adrs = a;
        tick();
        r_en = 1'b0;
        chk({name, " l1 valid"}, 32'(rd_valid1), 32'd1);
        chk({name, " l1 data"}, rd_data1, exp);
        chk({name, " l1 perr"}, 32'(rd_perr1), 32'(perr));
        chk({name, " l2 early valid"}, 32'(rd_valid2), 32'd0);
        tick();
        chk({name, " l2 valid"}, 32'(rd_valid2), 32'd1);
        chk({name, " l2 data"}, rd_data2, exp);
        chk({name, " l2 perr"}, 32'(rd_perr2), 32'(perr));
        chk({name, " l1 single pulse"}, 32'(rd_valid1), 32'd0);
        chk({name, " l1 hold"}, rd_data1, exp);
    endtask

    task automatic count_busy(output int n, output int nvalid);
        n = 0;
        nvalid = 0;
        while (busy1 && n < 3000) begin
            tick();
            n++;
            if (rd_valid1 || rd_valid2) nvalid++;
        end
    endtask

    initial begin
        int n, nv;

        vecs[0] = '{11'd5,    32'hDEADBEEF, 4'b1111, 1'b0, 32'hDEADBEEF, 4'b0000};
        vecs[1] = '{11'd5,    32'h00001200, 4'b0010, 1'b0, 32'hDEAD12EF, 4'b0000};
        vecs[2] = '{11'd9,    32'h11111111, 4'b1111, 1'b0, 32'h11111111, 4'b0000};
        vecs[3] = '{11'd7,    32'hFFFFFFFF, 4'b0000, 1'b0, 32'h00000000, 4'b0000};
        vecs[4] = '{11'd2047, 32'hCAFEF00D, 4'b1001, 1'b0, 32'hCA00000D, 4'b0000};
        vecs[5] = '{11'd0,    32'h12345678, 4'b1100, 1'b0, 32'h12340000, 4'b0000};
        vecs[6] = '{11'd3,    32'h01020304, 4'b0100, 1'b1, 32'h00020000, INJ_PERR};
        vecs[7] = '{11'd3,    32'h01020304, 4'b0100, 1'b0, 32'h00020000, 4'b0000};

        // Reset and first clear
        w_en = 1'b1; r_en = 1'b1;
        repeat (3) tick();
        chk("reset busy", 32'(busy1), 32'd1);
        chk("reset rd_valid", 32'(rd_valid1), 32'd0);
        chk("reset rd_data", rd_data1, 32'd0);
        chk("reset rd_perr", 32'(rd_perr2), 32'd0);
        w_en = 1'b0; r_en = 1'b0;
        reset = 1'b0;
        count_busy(n, nv);
        chk("clear busy cycles", 32'(n), 32'd2048);
        chk("clear busy l2", 32'(busy2), 32'd0);
        do_read("cleared addr0", 11'd0, 32'h0, 4'b0);
        do_read("cleared addr100", 11'd100, 32'h0, 4'b0);

        for (int i = 0; i < 8; i++) begin
            do_write(vecs[i].adrs, vecs[i].data, vecs[i].be, vecs[i].inj);
            do_read($sformatf("vec%0d", i), vecs[i].adrs, vecs[i].exp_word, vecs[i].exp_perr);
        end

        // Same-address read during write
        w_en = 1'b1; w_adrs = 11'd9; w_data = 32'hAAAAAAAA; w_be = 4'b0011;
        r_en = 1'b1; r_adrs = 11'd9;
        tick();
        w_en = 1'b0; r_en = 1'b0;
        chk("rdw old valid", 32'(rd_valid1), 32'd1);
        chk("rdw old data", rd_data1, 32'h11111111);
        tick();
        chk("rdw new valid", 32'(rd_valid2), 32'd1);
        chk("rdw new data", rd_data2, 32'h1111AAAA);
        chk("rdw new perr", 32'(rd_perr2), 32'd0);
        do_read("after rdw", 11'd9, 32'h1111AAAA, 4'b0);

        // Different addresses on the same edge do not interact
        w_en = 1'b1; w_adrs = 11'd10; w_data = 32'h55555555; w_be = 4'b1111;
        r_en = 1'b1; r_adrs = 11'd9;
        tick();
        w_en = 1'b0; r_en = 1'b0;
        chk("diff adrs l1", rd_data1, 32'h1111AAAA);
        tick();
        chk("diff adrs l2", rd_data2, 32'h1111AAAA);
        do_read("addr10", 11'd10, 32'h55555555, 4'b0);

        // Back-to-back burst
        for (int i = 0; i < 8; i++) do_write(AW'(i), {4{8'(i + 16)}}, 4'b1111, 1'b0);
        for (int c = 0; c < 10; c++) begin
            r_en = (c < 8);
            r_adrs = AW'(c);
            tick();
            chk($sformatf("burst l1 valid c%0d", c), 32'(rd_valid1), 32'(c < 8));
            if (c < 8) chk($sformatf("burst l1 data c%0d", c), rd_data1, {4{8'(c + 16)}});
            chk($sformatf("burst l2 valid c%0d", c), 32'(rd_valid2), 32'(c >= 1 && c <= 8));
            if (c >= 1 && c <= 8) chk($sformatf("burst l2 data c%0d", c), rd_data2, {4{8'(c + 15)}});
        end
        r_en = 1'b0;

        // Read in flight when reset hits is discarded
        r_en = 1'b1; r_adrs = 11'd5;
        tick();
        r_en = 1'b0; reset = 1'b1;
        tick();
        chk("flush l2 valid", 32'(rd_valid2), 32'd0);
        chk("flush l2 data", rd_data2, 32'd0);
        tick();
        reset = 1'b0;
        repeat (1000) tick();
        chk("mid clear busy", 32'(busy1), 32'd1);

        // Reset mid-clear with requests held high
        w_en = 1'b1; w_adrs = 11'd5; w_data = 32'hFFFFFFFF; w_be = 4'b1111;
        r_en = 1'b1; r_adrs = 11'd5;
        reset = 1'b1;
        repeat (3) tick();
        chk("reclear busy in reset", 32'(busy2), 32'd1);
        chk("reclear valid in reset", 32'(rd_valid1 | rd_valid2), 32'd0);
        reset = 1'b0;
        count_busy(n, nv);
        w_en = 1'b0; r_en = 1'b0;
        chk("reclear busy cycles", 32'(n), 32'd2048);
        chk("reclear no valid", 32'(nv), 32'd0);
        do_read("reclear addr5", 11'd5, 32'h0, 4'b0);
        do_read("reclear addr2047", 11'd2047, 32'h0, 4'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipelined_dp_ram.md
Name: pipelined_dp_ram

Overview:
Parametrised simple dual-port RAM, one write port and one read port, for the pipelined CPU's instruction/data stores.
- Adds per-byte write enables, a configurable read latency, selectable read-during-write behaviour and a read-valid strobe.
- Clears its contents with a sequencer that walks the address space after reset. Contents are not zeroed in a single cycle.
- While the sequencer runs, a busy flag stalls the pipeline.

Parameters:
DATA_W, 32, data width in bits; must be a multiple of 8
ADDR_W, 11, address width; depth = 2**ADDR_W words
RD_LAT, 1, read latency in cycles; legal values 1 or 2
RDW_NEW, 0, same-address read and write in one cycle: 0 returns old data, 1 returns new (forwarded) data

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
w_adrs  in  ADDR_W  write address
w_data  in  DATA_W  write data
w_be  in  DATA_W/8  byte write enables, bit i covers bits [8i+7:8i]
w_en  in  1  write request
w_perr_inj  in  1  inverts stored parity of the bytes written this cycle (parity builds only)
r_adrs  in  ADDR_W  read address
r_en  in  1  read request
rd_data  out  DATA_W  read data
rd_valid  out  1  rd_data is valid this cycle
rd_perr  out  DATA_W/8  per-byte parity error, aligned with rd_valid
busy  out  1  clear sequence in progress; requests are ignored

Behaviour:
- Reset (sampled high on an edge):
  - state goes to CLEAR and clr_adrs to 0.
  - rd_data, rd_valid and rd_perr go to 0, busy goes to 1.
  - The read pipeline is flushed.
  - While reset stays high, nothing is written and the state holds.
- FSM has two states, CLEAR and READY.
- CLEAR:
  - Each cycle with reset low writes 0 (and correct parity) to mem[clr_adrs], then clr_adrs increments.
  - On the cycle that writes address 2**ADDR_W-1, next state is READY.
  - busy is 1 for exactly 2**ADDR_W cycles after reset deasserts, and falls on the edge entering READY.
  - Reset asserted mid-clear restarts at address 0.
- While busy: w_en and r_en are ignored, no read is issued, and rd_valid stays 0.
- Write (READY):
  - Occurs on the edge where w_en=1.
  - Only bytes with w_be[i]=1 are updated. w_be=0 with w_en=1 is a no-op.
- Read (READY):
  - r_en=1 sampled on edge t gives rd_valid=1 and rd_data on edge t+RD_LAT.
  - Back-to-back reads give one result per cycle; throughput is 1.
  - rd_valid is 1 for exactly one cycle per accepted read.
- rd_data holds its last value while rd_valid=0.
- Read-during-write to the same address on the same edge:
  - RDW_NEW=0: returns the pre-write word.
  - RDW_NEW=1: returns the word with the enabled bytes replaced by w_data and the other bytes keeping their old value.
  - Different addresses do not interact.
- RD_LAT=2 adds one output register stage. Forwarding is resolved at stage 1.
- A read issued just before reset asserts is discarded; no rd_valid follows reset.

Optional Feature:
Macro: PIPELINED_DP_RAM_PARITY_EN.
- Defined:
  - Each byte stores an extra even-parity bit, computed from w_data, or the constant for 0 during CLEAR.
  - w_perr_inj=1 inverts the stored parity bit of every enabled byte.
  - On read, parity is recomputed over each byte. rd_perr[i]=1 if byte i mismatches, with the same timing as rd_data.
  - A forwarded word (RDW_NEW=1) uses the parity being written for enabled bytes.
- Undefined:
  - No parity storage.
  - rd_perr is tied to 0 and w_perr_inj is ignored.

Test Plan:
1. Reset 3 cycles, then release -> busy=1 for 2048 cycles, falls on cycle 2048; read of any address returns 0x00000000 with rd_perr=0.
2. Write 0xDEADBEEF to addr 5 with w_be=4'b1111, then a write with w_be=4'b0010, w_data=0x00001200 -> read addr 5 returns 0xDEAD12EF, rd_valid exactly RD_LAT cycles after r_en.
3. Addr 9 holds 0x11111111; same-edge write 0xAAAAAAAA with w_be=4'b0011 and read of addr 9 -> RDW_NEW=0 returns 0x11111111, RDW_NEW=1 returns 0x1111AAAA.
4. Reads of addrs 0..7 on 8 consecutive cycles with RD_LAT=2 -> 8 consecutive rd_valid pulses starting 2 cycles after the first read, data in order.
5. Reset asserted at clear cycle 1000, with w_en and r_en held high throughout -> clear restarts at 0, busy lasts a further 2048 cycles after release, no rd_valid and no write takes effect.
6. PARITY_EN: write 0x01020304 to addr 3 with w_be=4'b0100 and w_perr_inj=1 -> reading addr 3 returns rd_perr=4'b0100; a rewrite without injection clears it to 0.
